// File: rtl/prbs_pkg.sv
// Shared definitions for the 8-bit PRBS family (x^8+x^4+x^3+x^2+1).
//   prbs_chk_state_e : checker lock state (FILL -> SEARCH -> LOCKED)
//   PRBS8_TAPS       : history taps 3,4,5,7 (hist[0] is the most recent bit)
//   prbs8_expected() : next bit predicted from an 8-bit history
package prbs_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } prbs_chk_state_e;

    localparam logic [7:0] PRBS8_TAPS = 8'b1011_1000;

    // b[n] = b[n-4] ^ b[n-5] ^ b[n-6] ^ b[n-8]; with hist[k] = b[n-1-k]
    // those are history bits 3,4,5,7.
    function automatic logic prbs8_expected(input logic [7:0] hist);
        return ^(hist & PRBS8_TAPS);
    endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// Received PRBS bit stream.
//   in_bit   : received bit
//   in_valid : in_bit carries a bit this cycle
// Handshake: push-only stream. A bit transfers on every rising clk edge
// where in_valid=1; there is no ready/backpressure, the checker accepts
// every valid bit. in_bit is ignored while in_valid=0.
interface prbs_checker_if;
    logic in_bit;
    logic in_valid;

    modport master (output in_bit, output in_valid);
    modport slave  (input  in_bit, input  in_valid);
endinterface

// File: rtl/prbs8_predictor.sv
// 8-bit history register and next-bit predictor.
//   clk, reset_n     : clock, async active-low reset (history = 0)
//   shift_en_i       : shift one bit into the history
//   clear_i          : zero the history (wins over shift_en_i)
//   sel_expected_i   : shift source: 1 = own prediction, 0 = rx_bit_i
//   rx_bit_i         : received bit
//   expected_o       : predicted value of the next bit
//   history_zero_o   : history is all zeros
module prbs8_predictor
    import prbs_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic shift_en_i,
    input  logic clear_i,
    input  logic sel_expected_i,
    input  logic rx_bit_i,
    output logic expected_o,
    output logic history_zero_o
);

    logic [7:0] hist_q;
    logic [7:0] hist_d;
    logic       shift_bit;

    always_comb begin
        shift_bit = sel_expected_i ? expected_o : rx_bit_i;
        hist_d    = hist_q;
        if (clear_i) begin
            hist_d = '0;
        end else if (shift_en_i) begin
            hist_d = {hist_q[6:0], shift_bit};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign expected_o     = prbs8_expected(hist_q);
    assign history_zero_o = (hist_q == '0);

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising checker for the x^8+x^4+x^3+x^2+1 PRBS bit stream.
// Locks without knowing the seed, then counts checked bits and errors.
//   clk, reset_n  : clock, async active-low reset
//   rx            : received stream (in_bit / in_valid)
//   clear_counts  : synchronous clear of bit_count / err_count
//   locked        : checker is in LOCKED
//   bit_error     : 1-cycle pulse, bit accepted last cycle mismatched while LOCKED
//   bit_count     : valid bits checked while LOCKED (saturating)
//   err_count     : mismatches while LOCKED (saturating)
//   dbg_state_o   : current FSM state
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int unsigned LOCK_COUNT  = 16,
    parameter int unsigned WINDOW      = 64,
    parameter int unsigned UNLOCK_ERRS = 4,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    prbs_checker_if.slave          rx,
    input  logic                   clear_counts,
    output logic                   locked,
    output logic                   bit_error,
    output logic [COUNT_WIDTH-1:0] bit_count,
    output logic [COUNT_WIDTH-1:0] err_count,
    output prbs_chk_state_e        dbg_state_o
);

    localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
    localparam int unsigned WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int unsigned EW = $clog2(UNLOCK_ERRS + 1);

    prbs_chk_state_e        state_q, state_d;
    logic [2:0]             fill_q, fill_d;
    logic [MW-1:0]          match_q, match_d;
    logic [WW-1:0]          wbits_q, wbits_d;
    logic [EW-1:0]          werrs_q, werrs_d;
    logic                   bit_error_q, bit_error_d;
    logic [COUNT_WIDTH-1:0] bit_count_q, bit_count_d;
    logic [COUNT_WIDTH-1:0] err_count_q, err_count_d;

    logic shift_en, hist_clear, sel_expected;
    logic expected, history_zero, mismatch;
    logic bc_inc, ec_inc, wrap;

    prbs8_predictor u_pred (
        .clk            (clk),
        .reset_n        (reset_n),
        .shift_en_i     (shift_en),
        .clear_i        (hist_clear),
        .sel_expected_i (sel_expected),
        .rx_bit_i       (rx.in_bit),
        .expected_o     (expected),
        .history_zero_o (history_zero)
    );

    always_comb begin
        state_d      = state_q;
        fill_d       = fill_q;
        match_d      = match_q;
        wbits_d      = wbits_q;
        werrs_d      = werrs_q;
        bit_error_d  = 1'b0;
        shift_en     = 1'b0;
        hist_clear   = 1'b0;
        bc_inc       = 1'b0;
        ec_inc       = 1'b0;
        // Once locked the history free-runs on its own prediction, so a
        // flipped input bit costs exactly one error instead of several.
        sel_expected = (state_q == LOCKED);
        mismatch     = (rx.in_bit != expected);
        wrap         = (wbits_q == WW'(WINDOW - 1));

        if (rx.in_valid) begin
            case (state_q)
                FILL: begin
                    shift_en = 1'b1;
                    fill_d   = fill_q + 3'd1;   // 8th bit wraps back to 0
                    if (fill_q == 3'd7) begin
                        state_d = SEARCH;
                        match_d = '0;
                    end
                end
                SEARCH: begin
                    shift_en = 1'b1;
                    // All-zero history predicts 0 forever; refuse to count
                    // matches there so a stuck-0 line never locks.
                    if (!mismatch && !history_zero) begin
                        if (match_q == MW'(LOCK_COUNT - 1)) begin
                            state_d = LOCKED;
                            match_d = '0;
                            wbits_d = '0;
                            werrs_d = '0;
                        end else begin
                            match_d = match_q + MW'(1);
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    shift_en    = 1'b1;
                    bc_inc      = 1'b1;
                    wbits_d     = wrap ? '0 : wbits_q + WW'(1);
                    bit_error_d = mismatch;
                    ec_inc      = mismatch;
                    // An error on the last bit of a window still counts
                    // towards that window before it is cleared.
                    if (mismatch && (werrs_q == EW'(UNLOCK_ERRS - 1))) begin
                        state_d    = FILL;
                        hist_clear = 1'b1;
                        fill_d     = '0;
                    end else if (wrap) begin
                        werrs_d = '0;
                    end else if (mismatch) begin
                        werrs_d = werrs_q + EW'(1);
                    end
                end
                default: begin
                    state_d    = FILL;
                    hist_clear = 1'b1;
                    fill_d     = '0;
                end
            endcase
        end

        bit_count_d = bit_count_q;
        err_count_d = err_count_q;
        if (clear_counts) begin
            bit_count_d = '0;
            err_count_d = '0;
        end else begin
            if (bc_inc && (bit_count_q != '1)) bit_count_d = bit_count_q + 1'b1;
            if (ec_inc && (err_count_q != '1)) err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= FILL;
            fill_q      <= '0;
            match_q     <= '0;
            wbits_q     <= '0;
            werrs_q     <= '0;
            bit_error_q <= 1'b0;
            bit_count_q <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            wbits_q     <= wbits_d;
            werrs_q     <= werrs_d;
            bit_error_q <= bit_error_d;
            bit_count_q <= bit_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked      = (state_q == LOCKED);
    assign bit_error   = bit_error_q;
    assign bit_count   = bit_count_q;
    assign err_count   = err_count_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_prbs_checker.sv
module tb_prbs_checker;
    import prbs_pkg::*;

    localparam int unsigned LOCK_COUNT  = 16;
    localparam int unsigned WINDOW      = 64;
    localparam int unsigned UNLOCK_ERRS = 4;
    localparam int unsigned CW          = 32;
    localparam int unsigned W           = 2 + 2 * CW;

    // ---------------- clock / reset / DUT ----------------
    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            clear_counts = 1'b0;
    logic            locked, bit_error;
    logic [CW-1:0]   bit_count, err_count;
    prbs_chk_state_e dbg_state;

    prbs_checker_if rx();

    prbs_checker #(
        .LOCK_COUNT  (LOCK_COUNT),
        .WINDOW      (WINDOW),
        .UNLOCK_ERRS (UNLOCK_ERRS),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx           (rx),
        .clear_counts (clear_counts),
        .locked       (locked),
        .bit_error    (bit_error),
        .bit_count    (bit_count),
        .err_count    (err_count),
        .dbg_state_o  (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- PRBS source (recurrence) ----------------
    bit g_hist[$];   // last 8 generated bits, newest at the back

    function automatic bit gen_next();
        bit b;
        b = g_hist[$-3] ^ g_hist[$-4] ^ g_hist[$-5] ^ g_hist[$-7];
        g_hist.push_back(b);
        if (g_hist.size() > 8) void'(g_hist.pop_front());
        return b;
    endfunction

    // ---------------- reference model ----------------
    // phase: 0 = filling history, 1 = searching, 2 = locked
    int            m_phase, m_fill, m_run, m_wpos, m_werr;
    bit            m_win[$];
    logic          m_locked, m_berr;
    logic [CW-1:0] m_bc, m_ec;

    function automatic bit m_predict();
        return m_win[$-3] ^ m_win[$-4] ^ m_win[$-5] ^ m_win[$-7];
    endfunction

    function automatic bit m_win_zero();
        foreach (m_win[i]) if (m_win[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void m_push(input bit b);
        m_win.push_back(b);
        if (m_win.size() > 8) void'(m_win.pop_front());
    endfunction

    function automatic void model_reset();
        m_phase = 0; m_fill = 0; m_run = 0; m_wpos = 0; m_werr = 0;
        m_win.delete();
        m_locked = 1'b0; m_berr = 1'b0; m_bc = '0; m_ec = '0;
    endfunction

    function automatic void model_step(input bit v, input bit b, input bit clr);
        bit p, bc_inc, ec_inc;
        m_berr = 1'b0; bc_inc = 1'b0; ec_inc = 1'b0;
        if (v) begin
            if (m_phase == 0) begin
                m_push(b);
                m_fill++;
                if (m_fill == 8) begin m_phase = 1; m_run = 0; end
            end else if (m_phase == 1) begin
                p = m_predict();
                if (b == p && !m_win_zero()) m_run++;
                else m_run = 0;
                m_push(b);
                if (m_run == LOCK_COUNT) begin
                    m_phase = 2; m_wpos = 0; m_werr = 0; m_run = 0;
                end
            end else begin
                p = m_predict();
                m_push(p);
                bc_inc = 1'b1;
                if (b != p) begin ec_inc = 1'b1; m_berr = 1'b1; m_werr++; end
                m_wpos++;
                if (m_werr == UNLOCK_ERRS) begin
                    m_phase = 0; m_fill = 0; m_win.delete();
                end else if (m_wpos == WINDOW) begin
                    m_wpos = 0; m_werr = 0;
                end
            end
        end
        if (clr) begin
            m_bc = '0; m_ec = '0;
        end else begin
            if (bc_inc && m_bc != '1) m_bc++;
            if (ec_inc && m_ec != '1) m_ec++;
        end
        m_locked = (m_phase == 2);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step(input bit v, input bit b, input bit clr);
        @(negedge clk);
        rx.in_valid  = v;
        rx.in_bit    = b;
        clear_counts = clr;
        model_step(v, b, clr);
        exp_q.push_back({m_locked, m_berr, m_bc, m_ec});
    endtask

    task automatic send_clean(input int n);
        repeat (n) step(1'b1, gen_next(), 1'b0);
    endtask

    // let the last stepped bit be consumed, then sample away from the edge
    task automatic peek();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rx.in_valid  = 1'b0;
        rx.in_bit    = 1'b0;
        clear_counts = 1'b0;
        reset_n      = 1'b0;
        model_reset();
        #1;
        check("rst_locked",    locked,    0);
        check("rst_bit_error", bit_error, 0);
        check("rst_bit_count", bit_count, 0);
        check("rst_err_count", err_count, 0);
        check("rst_state",     dbg_state, FILL);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({locked, bit_error, bit_count, err_count} !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard t=%0t: got locked=%0b bit_error=%0b bit_count=%0d err_count=%0d, required locked=%0b bit_error=%0b bit_count=%0d err_count=%0d",
                             $time, locked, bit_error, bit_count, err_count,
                             e[W-1], e[W-2], e[2*CW-1:CW], e[CW-1:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int nv, nlk;
        rx.in_valid = 1'b0;
        rx.in_bit   = 1'b0;
        g_hist      = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        model_reset();
        do_reset();

        // clean stream: lock after exactly 24 bits, no errors over 1000
        send_clean(23);
        peek(); check("t1_unlocked_at_23", locked, 0);
        send_clean(1);
        peek(); check("t1_locked_at_24", locked, 1);
        send_clean(1000 - 24);
        peek();
        check("t1_err_count", err_count, 0);
        check("t1_bit_count", bit_count, 976);

        // single flipped bit: one pulse, one error, lock held
        step(1'b1, gen_next() ^ 1'b1, 1'b0);
        peek();
        check("t2_pulse",     bit_error, 1);
        check("t2_err_count", err_count, 1);
        check("t2_locked",    locked,    1);
        send_clean(1);
        peek();
        check("t2_pulse_end", bit_error, 0);
        check("t2_err_hold",  err_count, 1);

        // move past the window holding the t2 error, clearing counts
        send_clean(63);
        step(1'b1, gen_next(), 1'b1);
        // four errors inside one window: loss of lock
        for (int i = 0; i < 14; i++)
            step(1'b1, gen_next() ^ bit'(i == 2 || i == 5 || i == 9 || i == 13), 1'b0);
        peek();
        check("t3_unlocked",  locked,    0);
        check("t3_err_count", err_count, 4);
        check("t3_pulse",     bit_error, 1);
        send_clean(23);
        peek(); check("t3_not_relocked_23", locked, 0);
        send_clean(1);
        peek(); check("t3_relocked_24", locked, 1);

        // stuck-0 stream never locks
        do_reset();
        repeat (200) step(1'b1, 1'b0, 1'b0);
        peek();
        check("t4_locked",    locked,    0);
        check("t4_bit_count", bit_count, 0);

        // 50% valid duty
        do_reset();
        nv = 0;
        while (nv < 23) begin
            if ($urandom_range(0, 1) == 1) begin
                step(1'b1, gen_next(), 1'b0);
                nv++;
            end else begin
                step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end
        end
        peek(); check("t5_unlocked_at_23", locked, 0);
        repeat ($urandom_range(0, 3)) step(1'b0, 1'b1, 1'b0);
        step(1'b1, gen_next(), 1'b0);
        peek(); check("t5_locked_at_24", locked, 1);
        nlk = 0;
        repeat (300) begin
            if ($urandom_range(0, 1) == 1) begin
                step(1'b1, gen_next(), 1'b0);
                nlk++;
            end else begin
                step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end
        end
        peek();
        check("t5_bit_count", bit_count, nlk);

        // clear in the same cycle as an error, then reset while locked
        step(1'b1, gen_next() ^ 1'b1, 1'b1);
        peek();
        check("t6_pulse",     bit_error, 1);
        check("t6_err_clear", err_count, 0);
        check("t6_bit_clear", bit_count, 0);
        check("t6_locked",    locked,    1);
        do_reset();

        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
